// File: rtl/stoplight_pkg.sv
// Shared types and lamp encodings for the stoplight phase sequencer.
// state_t encodings are the same whether or not STOPLIGHT_PED_EN is defined.
package stoplight_pkg;

  typedef enum logic [2:0] {
    StMainGreen  = 3'd0,
    StMainYellow = 3'd1,
    StAllRedA    = 3'd2,
    StSideGreen  = 3'd3,
    StSideYellow = 3'd4,
    StAllRedB    = 3'd5,
    StWalk       = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic int unsigned max4(int unsigned a, int unsigned b,
                                       int unsigned c, int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/stoplight_timer.sv
// Tick prescaler plus phase down-counter; `expired` pulses on the last tick of a phase.
// A load restarts the prescaler so every phase lasts exactly duration*TICK_DIV enabled cycles.
module stoplight_timer #(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W:0]   duration,
  input  logic             en,
  output logic             expired
);

  localparam int unsigned     PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick    = en & (pre_q == PreMax);
  assign expired = tick & (cnt_q == '0);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load) begin
      pre_d = '0;
      cnt_d = CNT_W'(duration - 1'b1);
    end else if (en) begin
      pre_d = (pre_q == PreMax) ? '0 : pre_q + 1'b1;
      // Counter parks at zero so a held MAIN_GREEN stays expired.
      if (tick && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    pre_q <= pre_d;
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stoplight_controller.sv
// Stoplight phase sequencer: main/side green-yellow-all-red cycle with latched requests.
// Define STOPLIGHT_PED_EN to add the WALK phase and the pedestrian request latch.
module stoplight_controller
  import stoplight_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 10,
  parameter int unsigned GREEN_TICKS  = 8,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned WALK_TICKS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int unsigned MaxTicks = max4(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, WALK_TICKS);
  localparam int unsigned CntW     = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam int unsigned DurW     = CntW + 1;

  localparam logic [DurW-1:0] GreenDur  = DurW'(GREEN_TICKS);
  localparam logic [DurW-1:0] YellowDur = DurW'(YELLOW_TICKS);
  localparam logic [DurW-1:0] AllRedDur = DurW'(ALLRED_TICKS);
  localparam logic [DurW-1:0] WalkDur   = DurW'(WALK_TICKS);

  state_t          state_q, state_d;
  logic            side_pend_q, side_pend_d;
  logic            green_done_q, green_done_d;
  logic            req_any, load, expired;
  logic [DurW-1:0] duration;

`ifdef STOPLIGHT_PED_EN
  logic ped_pend_q, ped_pend_d;
  assign req_any    = side_pend_q | ped_pend_q;
  // Set wins over the entry clear so a held button is re-served next round.
  assign ped_pend_d = ped_req | (ped_pend_q & ~((state_d == StWalk) & (state_q != StWalk)));
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign req_any        = side_pend_q;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StMainGreen:  if (en && (green_done_q || expired) && req_any) state_d = StMainYellow;
      StMainYellow: if (expired) state_d = StAllRedA;
`ifdef STOPLIGHT_PED_EN
      StAllRedA:    if (expired) state_d = side_pend_q ? StSideGreen : StWalk;
      StAllRedB:    if (expired) state_d = ped_pend_q ? StWalk : StMainGreen;
`else
      StAllRedA:    if (expired) state_d = StSideGreen;
      StAllRedB:    if (expired) state_d = StMainGreen;
`endif
      StSideGreen:  if (expired) state_d = StSideYellow;
      StSideYellow: if (expired) state_d = StAllRedB;
      StWalk:       if (expired) state_d = StMainGreen;
      default:      state_d = StAllRedB;
    endcase
  end

  assign load = rst | (state_d != state_q);

  always_comb begin
    duration = AllRedDur;
    if (!rst) begin
      unique case (state_d)
        StMainGreen, StSideGreen:   duration = GreenDur;
        StMainYellow, StSideYellow: duration = YellowDur;
        StWalk:                     duration = WalkDur;
        default:                    duration = AllRedDur;
      endcase
    end
  end

  assign side_pend_d  = side_req |
                        (side_pend_q & ~((state_d == StSideGreen) & (state_q != StSideGreen)));
  assign green_done_d = ~load & (green_done_q | ((state_q == StMainGreen) & expired));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StAllRedB;
      side_pend_q  <= 1'b0;
      green_done_q <= 1'b0;
`ifdef STOPLIGHT_PED_EN
      ped_pend_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      side_pend_q  <= side_pend_d;
      green_done_q <= green_done_d;
`ifdef STOPLIGHT_PED_EN
      ped_pend_q   <= ped_pend_d;
`endif
    end
  end

  stoplight_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CntW)
  ) u_timer (
    .clk      (clk),
    .load     (load),
    .duration (duration),
    .en       (en),
    .expired  (expired)
  );

  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    unique case (state_q)
      StMainGreen:  main_light = LAMP_GRN;
      StMainYellow: main_light = LAMP_YEL;
      StSideGreen:  side_light = LAMP_GRN;
      StSideYellow: side_light = LAMP_YEL;
      default:      ;
    endcase
  end

`ifdef STOPLIGHT_PED_EN
  assign walk = (state_q == StWalk);
`else
  assign walk = 1'b0;
`endif

  assign phase = state_q;

endmodule

// File: tb/tb_stoplight_controller.sv
// Scoreboard bench for stoplight_controller: a cycle-counting phase model feeds an expected queue.
// Follows STOPLIGHT_PED_EN the same way the design does.
module tb_stoplight_controller;
  import stoplight_pkg::*;

  localparam int unsigned TD     = 2;
  localparam int unsigned GREEN  = 4;
  localparam int unsigned YELLOW = 2;
  localparam int unsigned ALLRED = 1;
  localparam int unsigned WALKT  = 3;
`ifdef STOPLIGHT_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  typedef struct {
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk_l;
    logic [2:0] phase_l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic       walk;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  // Model: phase name, enabled cycles left in the phase, green-minimum flag, request flags.
  state_t m_phase = StAllRedB;
  int     m_left  = 0;
  bit     m_gdone, m_side, m_ped;

  stoplight_controller #(
    .TICK_DIV     (TD),
    .GREEN_TICKS  (GREEN),
    .YELLOW_TICKS (YELLOW),
    .ALLRED_TICKS (ALLRED),
    .WALK_TICKS   (WALKT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .phase      (phase)
  );

  initial forever #5 clk = ~clk;

  function automatic int dur_cycles(state_t s);
    case (s)
      StMainGreen, StSideGreen:   return GREEN * TD;
      StMainYellow, StSideYellow: return YELLOW * TD;
      StWalk:                     return WALKT * TD;
      default:                    return ALLRED * TD;
    endcase
  endfunction

  function automatic exp_t lamps_of(state_t s);
    exp_t e;
    e.main_l  = 3'b100;
    e.side_l  = 3'b100;
    e.walk_l  = (s == StWalk);
    e.phase_l = s;
    if (s == StMainGreen)  e.main_l = 3'b001;
    if (s == StMainYellow) e.main_l = 3'b010;
    if (s == StSideGreen)  e.side_l = 3'b001;
    if (s == StSideYellow) e.side_l = 3'b010;
    return e;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit s, input bit p);
    state_t np;
    bit     expire;
    if (r) begin
      m_phase = StAllRedB;
      m_left  = dur_cycles(StAllRedB);
      m_gdone = 0;
      m_side  = 0;
      m_ped   = 0;
      return;
    end
    expire = e && (m_left == 1);
    np     = m_phase;
    case (m_phase)
      StMainGreen:  if (e && (m_gdone || expire) && (m_side || (PED && m_ped))) np = StMainYellow;
      StMainYellow: if (expire) np = StAllRedA;
      StAllRedA:    if (expire) np = (m_side || !PED) ? StSideGreen : StWalk;
      StSideGreen:  if (expire) np = StSideYellow;
      StSideYellow: if (expire) np = StAllRedB;
      StAllRedB:    if (expire) np = (PED && m_ped) ? StWalk : StMainGreen;
      default:      if (expire) np = StMainGreen;
    endcase
    if (m_phase == StMainGreen && expire) m_gdone = 1;
    m_side = s || (m_side && !(np == StSideGreen && m_phase != StSideGreen));
    m_ped  = PED && (p || (m_ped && !(np == StWalk && m_phase != StWalk)));
    if (np != m_phase) begin
      m_phase = np;
      m_left  = dur_cycles(np);
      m_gdone = 0;
    end else if (e && m_left > 0) begin
      m_left--;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit s, input bit p);
    @(negedge clk);
    rst      = r;
    en       = e;
    side_req = s;
    ped_req  = p;
    model_step(r, e, s, p);
    exp_q.push_back(lamps_of(m_phase));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0);
  endtask

  task automatic run_until(input state_t tgt, input int max_cycles);
    int n = 0;
    while (m_phase != tgt && n < max_cycles) begin
      cycle(0, 1, 0, 0);
      n++;
    end
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every edge presents a new Moore output; compare it with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("main_light", main_light, e.main_l);
        check("side_light", side_light, e.side_l);
        check("walk", {2'b00, walk}, {2'b00, e.walk_l});
        check("phase", phase, e.phase_l);
      end
    end
  end

  initial begin
    bit s_hold, p_hold;
    // Reset, then idle: MAIN_GREEN must hold.
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    idle(200);
    // Side pulse on MAIN_GREEN entry.
    cycle(1, 1, 0, 0);
    run_until(StMainGreen, 20);
    cycle(0, 1, 1, 0);
    idle(50);
    // Pedestrian pulse 20 cycles into MAIN_GREEN.
    idle(20);
    cycle(0, 1, 0, 1);
    idle(40);
    // Both requests together.
    idle(12);
    cycle(0, 1, 1, 1);
    idle(60);
    // Enable drop mid SIDE_GREEN.
    cycle(0, 1, 1, 0);
    run_until(StSideGreen, 60);
    idle(4);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    idle(40);
    // Reset during SIDE_YELLOW.
    cycle(0, 1, 1, 0);
    run_until(StSideYellow, 80);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    idle(20);
    // Held request levels are re-served every round.
    for (int i = 0; i < 60; i++) cycle(0, 1, 1, 1);
    idle(60);
    // Random traffic.
    s_hold = 0;
    p_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) s_hold = ~s_hold;
      if ($urandom_range(0, 149) == 0) p_hold = ~p_hold;
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) != 0),
            s_hold || ($urandom_range(0, 59) == 0), p_hold || ($urandom_range(0, 59) == 0));
    end
    @(negedge clk);
    repeat (3) @(posedge clk);
    #4;
    check("queue_drained", 3'(exp_q.size()), 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stoplight_controller.md
# stoplight_controller

Phase sequencer for the stoplight example: drives main-street and side-street lamp sets through green, yellow and all-red phases. Vehicle and pedestrian requests are latched until served; phase lengths are counted in prescaled ticks. Sits under `fpga_top`, between the input synchronizers/debouncers and the lamp output pins.

## Interface
- `TICK_DIV`, default 10: clock cycles per tick, must be ≥1.
- `GREEN_TICKS`, default 8: minimum main-green length and fixed side-green length, in ticks, must be ≥1.
- `YELLOW_TICKS`, default 3: yellow length, ticks, must be ≥1.
- `ALLRED_TICKS`, default 1: all-red clearance length, ticks, must be ≥1.
- `WALK_TICKS`, default 5: pedestrian walk length, ticks, must be ≥1.
- `clk  in  1`: single clock, all logic on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `en  in  1`: run enable. When 0, the prescaler and phase timer hold.
- `side_req  in  1`: side-street vehicle sensor, already synchronized, level or pulse.
- `ped_req  in  1`: pedestrian button, already synchronized and debounced, level or pulse.
- `main_light  out  3`: main-street lamps, {red, yellow, green}.
- `side_light  out  3`: side-street lamps, {red, yellow, green}.
- `walk  out  1`: walk lamp.
- `phase  out  3`: current `state_t` encoding, for debug and LEDs.

## Operation
- States: MAIN_GREEN, MAIN_YELLOW, ALL_RED_A, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B, WALK.
- Outputs are a Moore decode of the state register:
  - MAIN_GREEN: main 001, side 100.
  - MAIN_YELLOW: main 010, side 100.
  - SIDE_GREEN: main 100, side 001.
  - SIDE_YELLOW: main 100, side 010.
  - ALL_RED_A, ALL_RED_B, WALK: both 100.
  - `walk`=1 only in WALK.
- Request latches:
  - `side_pend` is set on any cycle with `side_req`=1 and cleared on entry to SIDE_GREEN.
  - `ped_pend` is set on any cycle with `ped_req`=1 and cleared on entry to WALK.
  - If set and clear fall in the same cycle, set wins. A held request is therefore re-latched and served in the next cycle round.
- Transitions:
  - MAIN_GREEN → MAIN_YELLOW when `green_done` & (`side_pend` | `ped_pend`). `green_done` sets once GREEN_TICKS have elapsed.
  - MAIN_YELLOW → ALL_RED_A.
  - ALL_RED_A → SIDE_GREEN if `side_pend`, else WALK.
  - SIDE_GREEN → SIDE_YELLOW → ALL_RED_B.
  - ALL_RED_B → WALK if `ped_pend`, else MAIN_GREEN.
  - WALK → MAIN_GREEN.
- Simultaneous side and pedestrian requests: side is served first, then WALK is reached via ALL_RED_B.
- With no requests pending, MAIN_GREEN holds indefinitely.
- Reset:
  - State register goes to ALL_RED_B, timer loads ALLRED_TICKS, prescaler clears, both latches clear, `green_done` clears.
  - Outputs during and after reset: `main_light`=100, `side_light`=100, `walk`=0, `phase`=ALL_RED_B.
  - `rst` asserted mid-phase aborts the phase on the next edge; there is no yellow completion.

## Timing
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1.
  - `tick` fires in the cycle where prescaler = TICK_DIV-1 and `en`=1.
- Phase timer:
  - On state entry, prescaler ← 0 and timer ← duration-1.
  - On `tick` with timer=0, the phase expires.
  - A timed phase therefore lasts exactly duration×TICK_DIV enabled cycles; the new state is visible on the following edge.
- MAIN_GREEN:
  - Expiry sets `green_done`.
  - If a request is already pending at expiry, the exit happens on the same edge.
  - Otherwise the exit happens on the edge after the request is latched, i.e. 2 cycles after `req` rises.
- Counter width: $clog2 of the maximum of all durations, minimum 1 bit. The prescaler is $clog2(TICK_DIV) wide, minimum 1 bit.
- While `en`=0: state, prescaler and timer freeze; latches keep capturing requests.

## Configuration
- `STOPLIGHT_PED_EN` defined:
  - WALK state, `ped_pend` latch and `WALK_TICKS` are present, as described above.
- `STOPLIGHT_PED_EN` undefined:
  - No WALK state and no `ped_pend` latch; `ped_req` is ignored and `walk` is tied 0.
  - MAIN_GREEN exits on `green_done` & `side_pend` only.
  - ALL_RED_A always goes to SIDE_GREEN; ALL_RED_B always goes to MAIN_GREEN.
  - `state_t` encodings are identical in both builds.

## Structure
- `stoplight_pkg` holds:
  - `state_t` enum, 3 bits.
  - Lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001.
- Sub-module `stoplight_timer` contains prescaler + phase down-counter.
  - Inputs: `load`, `duration`, `en`.
  - Output: `expired` pulse.

## Test plan
All scenarios use TICK_DIV=2, GREEN=4, YELLOW=2, ALLRED=1, WALK=3, with `en`=1 unless stated.
- Reset: `rst`=1 for 2 cycles → lamps 100/100, `walk`=0. After release, 2 cycles of ALL_RED_B, then `main_light`=001.
- Idle: no requests for 200 cycles → MAIN_GREEN throughout.
- Side request: 1-cycle `side_req` pulse at MAIN_GREEN entry → main green 8 cycles, yellow 4, all-red 2, side green 8, side yellow 4, all-red 2, then main green. The latch is clear at side-green entry.
- Pedestrian request: `ped_req` pulse 20 cycles into MAIN_GREEN → yellow starts 2 cycles later. After 4 cycles of yellow and 2 of all-red, `walk`=1 for 6 cycles with both sets red, then MAIN_GREEN.
- Both requests in the same cycle → side phases first, then ALL_RED_B → WALK → MAIN_GREEN.
- Enable and reset mid-operation:
  - `en`=0 for 10 cycles in mid SIDE_GREEN → side green lasts 18 cycles.
  - `rst` pulse during SIDE_YELLOW → next cycle shows lamps 100/100 and `phase`=ALL_RED_B.
